// File: rtl/mcdt_formatter.sv
// Packet formatter: buffers the distributor's interleaved stream into three
// per-channel FIFOs and emits fixed-length packets round-robin under req/grant.
module mcdt_formatter #(
  parameter int FIFO_DEPTH = 32,
  parameter int PKT_LEN    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_val_i,
  input  logic [31:0]                 in_data_i,
  input  logic [1:0]                  in_id_i,
  output logic                        fmt_req_o,
  output logic [1:0]                  fmt_chid_o,
  input  logic                        fmt_grant_i,
  output logic                        fmt_val_o,
  output logic [31:0]                 fmt_data_o,
  output logic                        fmt_start_o,
  output logic                        fmt_end_o,
  output logic [$clog2(FIFO_DEPTH):0] ch0_free_o,
  output logic [$clog2(FIFO_DEPTH):0] ch1_free_o,
  output logic [$clog2(FIFO_DEPTH):0] ch2_free_o,
  output logic [2:0]                  ovf_o,
  output logic                        bad_id_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = $clog2(PKT_LEN + 1);

  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  PKT_C     = CW'(PKT_LEN);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      chid_q, chid_d;
  logic [1:0]      lastServed_q, lastServed_d;
  logic [WCW-1:0]  wordCnt_q, wordCnt_d;
  logic [2:0]      ovf_q, ovf_d;
  logic            badId_q, badId_d;

  logic [AW-1:0]   wrPtr_q [3];
  logic [AW-1:0]   rdPtr_q [3];
  logic [CW-1:0]   count_q [3];
  logic [31:0]     mem_q   [3][FIFO_DEPTH];

  logic [2:0]      push;
  logic [2:0]      pop;
  logic [2:0]      ovfSet;
  logic [2:0]      elig;
  logic            badSet;

  logic [1:0]      rrStart;
  logic [1:0]      rrWin;
  logic            rrFound;
  logic [2:0]      rrSum;
  logic [1:0]      rrCand;

  // Pop happens on every SEND cycle of the served channel; eligibility is a
  // whole packet's worth of data.
  always_comb begin
    pop  = '0;
    elig = '0;
    for (int c = 0; c < 3; c++) begin
      pop[c]  = (state_q == ST_SEND) && (chid_q == 2'(c));
      elig[c] = (count_q[c] >= PKT_C);
    end
  end

  // A full FIFO still accepts a word when it is popped in the same cycle.
  always_comb begin
    push   = '0;
    ovfSet = '0;
    for (int c = 0; c < 3; c++) begin
      push[c]   = in_val_i && (in_id_i == 2'(c)) && ((count_q[c] < DEPTH_C) || pop[c]);
      ovfSet[c] = in_val_i && (in_id_i == 2'(c)) && !((count_q[c] < DEPTH_C) || pop[c]);
    end
    badSet  = in_val_i && (in_id_i == 2'd3);
    ovf_d   = ovf_q | ovfSet;
    badId_d = badId_q | badSet;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < 3; c++) begin
        wrPtr_q[c] <= '0;
        rdPtr_q[c] <= '0;
        count_q[c] <= '0;
      end
      ovf_q   <= '0;
      badId_q <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (push[c]) wrPtr_q[c] <= wrPtr_q[c] + AW'(1);
        if (pop[c])  rdPtr_q[c] <= rdPtr_q[c] + AW'(1);
        if (push[c] && !pop[c]) begin
          count_q[c] <= count_q[c] + CW'(1);
        end else if (pop[c] && !push[c]) begin
          count_q[c] <= count_q[c] - CW'(1);
        end
      end
      ovf_q   <= ovf_d;
      badId_q <= badId_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < 3; c++) begin
      if (push[c]) mem_q[c][wrPtr_q[c]] <= in_data_i;
    end
  end

  // Round-robin search begins one past the last served channel, modulo 3.
  always_comb begin
    rrStart = (lastServed_q == 2'd2) ? 2'd0 : lastServed_q + 2'd1;
    rrWin   = rrStart;
    rrFound = 1'b0;
    rrSum   = '0;
    rrCand  = '0;
    for (int k = 0; k < 3; k++) begin
      rrSum  = {1'b0, rrStart} + 3'(k);
      rrCand = (rrSum >= 3'd3) ? 2'(rrSum - 3'd3) : rrSum[1:0];
      if (!rrFound && elig[rrCand]) begin
        rrWin   = rrCand;
        rrFound = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      chid_q       <= 2'd0;
      lastServed_q <= 2'd2;
      wordCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      chid_q       <= chid_d;
      lastServed_q <= lastServed_d;
      wordCnt_q    <= wordCnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    chid_d       = chid_q;
    lastServed_d = lastServed_q;
    wordCnt_d    = wordCnt_q;
    fmt_req_o    = 1'b0;
    fmt_val_o    = 1'b0;
    fmt_start_o  = 1'b0;
    fmt_end_o    = 1'b0;
    fmt_data_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (rrFound) begin
          chid_d  = rrWin;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        fmt_req_o = 1'b1;
        if (fmt_grant_i) begin
          state_d      = ST_SEND;
          wordCnt_d    = '0;
          lastServed_d = chid_q;
        end
      end
      ST_SEND: begin
        fmt_val_o   = 1'b1;
        fmt_data_o  = mem_q[chid_q][rdPtr_q[chid_q]];
        fmt_start_o = (wordCnt_q == '0);
        fmt_end_o   = (wordCnt_q == LAST_WORD);
        wordCnt_d   = wordCnt_q + WCW'(1);
        if (wordCnt_q == LAST_WORD) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fmt_chid_o = chid_q;
  assign ch0_free_o = DEPTH_C - count_q[0];
  assign ch1_free_o = DEPTH_C - count_q[1];
  assign ch2_free_o = DEPTH_C - count_q[2];
  assign ovf_o      = ovf_q;
  assign bad_id_o   = badId_q;

endmodule
